// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN weight-loading path.
// KERNEL_SIZE / NUM_FEATURES set the kernel geometry; KK is the number
// of weight bits per feature kernel and ADDR_W the weight-memory address width.
package cnn_pkg;

    localparam int KERNEL_SIZE  = 3;
    localparam int NUM_FEATURES = 10;
    localparam int KK           = KERNEL_SIZE * KERNEL_SIZE;
    localparam int ADDR_W       = $clog2(NUM_FEATURES) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_e;

    // Counter width that still works for a single-element count.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/weight_loader_if.sv
// Bus between the weight loader, its serial bit source, its controller and
// the weight memory.
//   master : the loader (drives ser_ready, address_w, feature_WrEn,
//            weights_input, busy, done)
//   slave  : the surrounding system (drives start, ser_bit, ser_valid)
interface weight_loader_if #(
    parameter int KK_P = cnn_pkg::KK,
    parameter int AW_P = cnn_pkg::ADDR_W
);
    logic            start;
    logic            ser_bit;
    logic            ser_valid;
    logic            ser_ready;
    logic [AW_P-1:0] address_w;
    logic            feature_WrEn;
    logic            weights_input [KK_P];
    logic            busy;
    logic            done;

    modport master (
        input  start, ser_bit, ser_valid,
        output ser_ready, address_w, feature_WrEn, weights_input, busy, done
    );

    modport slave (
        output start, ser_bit, ser_valid,
        input  ser_ready, address_w, feature_WrEn, weights_input, busy, done
    );
endinterface

// File: rtl/kernel_deser.sv
// Kernel deserialiser: stores each accepted bit at element index bit_cnt
// (element 0 first) and flags when the next accepted bit completes the kernel.
//   clk, rst     : clock, async active-low reset
//   clear_i      : restart a kernel (bit_cnt=0, storage cleared)
//   shift_en_i   : accept bit_i this cycle
//   bit_i        : serial weight bit
//   kernel_d_o   : next-state kernel, includes the bit being accepted now
//   last_o       : bit_cnt is at the final element
module kernel_deser #(
    parameter int KBITS = cnn_pkg::KK
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic shift_en_i,
    input  logic bit_i,
    output logic kernel_d_o [KBITS],
    output logic last_o
);
    import cnn_pkg::*;

    localparam int            CW       = cnt_width(KBITS);
    localparam logic [CW-1:0] LAST_IDX = CW'(KBITS - 1);

    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic          kernel_q [KBITS];

    assign last_o = (bit_cnt_q == LAST_IDX);

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        kernel_d_o = kernel_q;
        if (clear_i) begin
            bit_cnt_d = '0;
            for (int i = 0; i < KBITS; i++) kernel_d_o[i] = 1'b0;
        end else if (shift_en_i) begin
            kernel_d_o[bit_cnt_q] = bit_i;
            bit_cnt_d = last_o ? '0 : bit_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_q <= '0;
            kernel_q  <= '{default: 1'b0};
        end else begin
            bit_cnt_q <= bit_cnt_d;
            kernel_q  <= kernel_d_o;
        end
    end

endmodule

// File: rtl/weight_loader.sv
// Weight loader: on start, deserialises NUM_FEATURES kernels of KK bits each
// and writes each one to the weight memory with a one-cycle active-low strobe.
//   clk, rst : clock, async active-low reset
//   bus      : weight_loader_if.master (start/serial input, memory write port,
//              busy/done status)
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   ST_IDLE  | waiting for start, serial input not accepted
//   ST_SHIFT | accepting kernel bits for feature feat_cnt
//   ST_WRITE | one-cycle memory write of the assembled kernel
//   ST_DONE  | one-cycle done pulse, then back to idle
module weight_loader #(
    parameter int KERNEL_SIZE  = cnn_pkg::KERNEL_SIZE,
    parameter int NUM_FEATURES = cnn_pkg::NUM_FEATURES
) (
    input  logic clk,
    input  logic rst,
    weight_loader_if.master bus
);
    import cnn_pkg::*;

    localparam int            KBITS     = KERNEL_SIZE * KERNEL_SIZE;
    localparam int            AW        = $clog2(NUM_FEATURES) + 1;
    localparam logic [AW-1:0] LAST_FEAT = AW'(NUM_FEATURES - 1);

    loader_state_e state_q, state_d;
    logic [AW-1:0] feat_q, feat_d;
    logic          clear, accept, last_bit;
    logic          kernel_d [KBITS];

    logic          ser_ready_q, busy_q, done_q, wren_q;
    logic [AW-1:0] addr_q;
    logic          weights_q [KBITS];

    kernel_deser #(.KBITS(KBITS)) u_deser (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (clear),
        .shift_en_i (accept),
        .bit_i      (bus.ser_bit),
        .kernel_d_o (kernel_d),
        .last_o     (last_bit)
    );

    // ser_ready_q is exactly (state_q == ST_SHIFT), so accept matches the
    // handshake seen outside.
    assign accept = (state_q == ST_SHIFT) && bus.ser_valid;

    always_comb begin
        state_d = state_q;
        feat_d  = feat_q;
        clear   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_SHIFT;
                    feat_d  = '0;
                    clear   = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (accept && last_bit) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (feat_q == LAST_FEAT) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                    feat_d  = feat_q + AW'(1);
                    clear   = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so that the write strobe,
    // address and data all change together on the rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            feat_q      <= '0;
            ser_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wren_q      <= 1'b1;
            addr_q      <= '0;
            weights_q   <= '{default: 1'b0};
        end else begin
            state_q     <= state_d;
            feat_q      <= feat_d;
            ser_ready_q <= (state_d == ST_SHIFT);
            busy_q      <= (state_d == ST_SHIFT) || (state_d == ST_WRITE);
            done_q      <= (state_d == ST_DONE);
            wren_q      <= (state_d != ST_WRITE);
            if (state_d == ST_WRITE) begin
                addr_q    <= feat_q;
                weights_q <= kernel_d;
            end
        end
    end

    assign bus.ser_ready     = ser_ready_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.feature_WrEn  = wren_q;
    assign bus.address_w     = addr_q;
    assign bus.weights_input = weights_q;

endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench for weight_loader: randomized serial streams checked
// against a timeline model built from the load-sequence rules.
module tb_weight_loader;
    import cnn_pkg::*;

    localparam int NF    = NUM_FEATURES;
    localparam int NB    = KK;
    localparam int MAXC  = 1024;
    // Cycle right after the 4th bit of feature 3 with continuous ser_valid.
    localparam int ABORT = 3 * (NB + 1) + 1 + 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    weight_loader_if bus ();

    weight_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic        vpat [MAXC];
    logic        bits [NF*NB];
    int          wc [NF];
    int          done_cyc;
    int          exp_addr;
    logic [31:0] mem [NF];
    logic [8:0]  pat0 = 9'b101001101;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] packed_w();
        logic [31:0] w = '0;
        for (int i = 0; i < NB; i++) w[i] = bus.weights_input[i];
        return w;
    endfunction

    function automatic logic [31:0] exp_kernel(input int f);
        logic [31:0] w = '0;
        for (int i = 0; i < NB; i++) w[i] = bits[f*NB + i];
        return w;
    endfunction

    // The weight memory: captures on the falling edge while the strobe is low.
    always @(negedge clk)
        if (rst && !bus.feature_WrEn && bus.address_w < NF)
            mem[bus.address_w] <= packed_w();

    // Each feature consumes NB valid cycles, then spends one cycle writing;
    // the cycle after the last write is the done cycle.
    task automatic build_model();
        int t = 1;
        for (int f = 0; f < NF; f++) begin
            int n = 0;
            while (n < NB && t < MAXC) begin
                if (vpat[t]) n++;
                t++;
            end
            wc[f] = t;
            t++;
        end
        done_cyc = t;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(bus.ser_ready), 0);
        check({tag, "_busy"},  32'(bus.busy), 0);
        check({tag, "_done"},  32'(bus.done), 0);
        check({tag, "_wren"},  32'(bus.feature_WrEn), 1);
        check({tag, "_addr"},  32'(bus.address_w), 0);
        check({tag, "_wts"},   packed_w(), 0);
    endtask

    // mode 0: continuous valid, feature f bits = f[0]
    // mode 1: continuous valid, feature 0 fixed pattern, others random
    // mode 2: valid toggles 1/0 starting high
    // mode 3: random valid (75%), extra start pulse at cycle 5
    // mode 4: random valid (50%)
    task automatic run_seq(input int mode, input int abort_at);
        int   idx = 0;
        logic prev_low = 1'b0;
        int   last_c;
        for (int c = 0; c < MAXC; c++) begin
            case (mode)
                0, 1:    vpat[c] = 1'b1;
                2:       vpat[c] = (c % 2) == 1;
                3:       vpat[c] = ($urandom % 4) != 0;
                default: vpat[c] = ($urandom % 2) != 0;
            endcase
        end
        vpat[0] = 1'b0;
        for (int f = 0; f < NF; f++)
            for (int b = 0; b < NB; b++) begin
                if (mode == 0)                bits[f*NB+b] = 1'((f % 2) != 0);
                else if (mode == 1 && f == 0) bits[f*NB+b] = (b < 9) ? pat0[b] : 1'b0;
                else                          bits[f*NB+b] = 1'($urandom);
            end
        build_model();
        last_c = (done_cyc + 3 < MAXC) ? done_cyc + 3 : MAXC - 1;

        @(posedge clk); #1;
        bus.start = 1'b1; bus.ser_valid = 1'b0; bus.ser_bit = 1'b0;
        for (int c = 0; c <= last_c; c++) begin
            int wf = -1;
            if (c > 0) begin
                @(posedge clk); #1;
                bus.start     = (mode == 3 && c == 5);
                bus.ser_valid = vpat[c];
                bus.ser_bit   = (idx < NF*NB) ? bits[idx] : 1'($urandom);
            end
            if (c == abort_at) begin
                rst = 1'b0;
                #1;
                check_reset_outputs("mid_rst");
                repeat (2) @(posedge clk);
                #1 rst = 1'b1;
                exp_addr = 0;
                bus.ser_valid = 1'b1;
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    check("post_rst_wren", 32'(bus.feature_WrEn), 1);
                    check("post_rst_busy", 32'(bus.busy), 0);
                end
                bus.ser_valid = 1'b0;
                return;
            end
            @(negedge clk);
            for (int f = 0; f < NF; f++) if (wc[f] == c) wf = f;
            check("wren",  32'(bus.feature_WrEn), (wf < 0) ? 1 : 0);
            check("busy",  32'(bus.busy), (c >= 1 && c < done_cyc) ? 1 : 0);
            check("done",  32'(bus.done), (c == done_cyc) ? 1 : 0);
            check("ready", 32'(bus.ser_ready), (c >= 1 && c < done_cyc && wf < 0) ? 1 : 0);
            if (wf >= 0) begin
                exp_addr = wf;
                check("weights", packed_w(), exp_kernel(wf));
            end
            check("addr", 32'(bus.address_w), exp_addr);
            check("addr_range", 32'(bus.address_w < NF), 1);
            check("wren_pair", 32'(prev_low && !bus.feature_WrEn), 0);
            prev_low = !bus.feature_WrEn;
            if (bus.ser_ready && bus.ser_valid) idx++;
        end
        bus.ser_valid = 1'b0;
        for (int f = 0; f < NF; f++) check("mem", mem[f], exp_kernel(f));
    endtask

    initial begin
        bus.start = 1'b0; bus.ser_valid = 1'b0; bus.ser_bit = 1'b0;
        exp_addr = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        bus.ser_valid = 1'b1;
        @(negedge clk);
        check("reset_ready_drop", 32'(bus.ser_ready), 0);
        bus.ser_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;

        run_seq(0, -1);
        run_seq(1, -1);
        run_seq(2, -1);
        run_seq(3, -1);
        run_seq(0, ABORT);
        run_seq(0, -1);
        run_seq(4, -1);
        run_seq(3, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
